// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP layer sequencer: FSM encodings, default
// widths matching cordic_neuron, and the parameter-bank address width helper.
package mlp_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_OUTPUT = 2'd3;

  localparam int DEF_INPUT_WIDTH  = 20;
  localparam int DEF_ACCUM_WIDTH  = 48;
  localparam int DEF_OUTPUT_WIDTH = 20;
  localparam int DEF_NUM_INPUTS   = 4;

  // At least one address bit, even for a single-entry bank.
  function automatic int bank_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mlp_param_bank.sv
// Per-neuron weight/bias register file: one write port, one combinational
// read port.
module mlp_param_bank
  import mlp_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = bank_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: this is flop storage, not a RAM macro, so it can and does take the
  // async reset; a reset layer must never run with stale weights.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Drives one cordic_neuron through NUM_NEURONS weight sets to evaluate a layer.
// Define LAYER_TIMEOUT_EN to add a per-neuron WAIT timeout and sticky timeout_err.
module mlp_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int INPUT_WIDTH    = DEF_INPUT_WIDTH,
  parameter int ACCUM_WIDTH    = DEF_ACCUM_WIDTH,
  parameter int OUTPUT_WIDTH   = DEF_OUTPUT_WIDTH,
  parameter int NUM_INPUTS     = DEF_NUM_INPUTS,
  parameter int NUM_NEURONS    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [INPUT_WIDTH*NUM_INPUTS-1:0]   in_data,
  input  logic                                wr_en,
  input  logic [$clog2(NUM_NEURONS)-1:0]      wr_addr,
  input  logic [INPUT_WIDTH*NUM_INPUTS-1:0]   wr_weights,
  input  logic [ACCUM_WIDTH-1:0]              wr_bias,
  output logic                                neuron_start,
  output logic [INPUT_WIDTH*NUM_INPUTS-1:0]   neuron_inputs_flat,
  output logic [INPUT_WIDTH*NUM_INPUTS-1:0]   neuron_weights_flat,
  output logic [ACCUM_WIDTH-1:0]              neuron_bias,
  input  logic [OUTPUT_WIDTH-1:0]             neuron_output_data,
  input  logic                                neuron_output_valid,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUTPUT_WIDTH*NUM_NEURONS-1:0] out_data,
  output logic                                busy,
  output logic                                timeout_err
);

  localparam int IDX_W   = bank_addr_w(NUM_NEURONS);
  localparam int VEC_W   = INPUT_WIDTH * NUM_INPUTS;
  localparam int ENTRY_W = VEC_W + ACCUM_WIDTH;
  localparam int RES_W   = OUTPUT_WIDTH * NUM_NEURONS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  logic [1:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [VEC_W-1:0]        in_vec_q, in_vec_d;
  logic [VEC_W-1:0]        weights_q, weights_d;
  logic [ACCUM_WIDTH-1:0]  bias_q, bias_d;
  logic [RES_W-1:0]        result_q, result_d;

  logic                    load_param;
  logic                    resp_fire;
  logic [OUTPUT_WIDTH-1:0] resp_data;
  logic                    wait_expired;
  logic                    bank_wr_en;
  logic [ENTRY_W-1:0]      bank_wr_data, bank_rd_data, param_next;

  assign bank_wr_en   = wr_en && (state_q == ST_IDLE);
  assign bank_wr_data = {wr_weights, wr_bias};

  // Read port follows the next index so the parameters are registered in
  // time for the ISSUE cycle.
  mlp_param_bank #(
    .DATA_W (ENTRY_W),
    .DEPTH  (NUM_NEURONS),
    .ADDR_W (IDX_W)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (bank_wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (bank_wr_data),
    .rd_addr_i (idx_d),
    .rd_data_o (bank_rd_data)
  );

  // A write landing on the same edge as acceptance must reach neuron 0.
  assign param_next = (bank_wr_en && (wr_addr == idx_d)) ? bank_wr_data : bank_rd_data;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    in_vec_d   = in_vec_q;
    result_d   = result_q;
    load_param = 1'b0;
    resp_fire  = 1'b0;
    resp_data  = neuron_output_data;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          in_vec_d   = in_data;
          idx_d      = '0;
          state_d    = ST_ISSUE;
          load_param = 1'b1;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (neuron_output_valid) begin
          resp_fire = 1'b1;
        end else if (wait_expired) begin
          resp_fire = 1'b1;
          resp_data = '0;
        end
      end
      ST_OUTPUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (resp_fire) begin
      result_d[int'(idx_q) * OUTPUT_WIDTH +: OUTPUT_WIDTH] = resp_data;
      if (idx_q == LAST_IDX) begin
        state_d = ST_OUTPUT;
      end else begin
        idx_d      = idx_q + 1'b1;
        state_d    = ST_ISSUE;
        load_param = 1'b1;
      end
    end
  end

  // Kept apart from the FSM block: param_next depends on idx_d.
  always_comb begin
    weights_d = weights_q;
    bias_d    = bias_q;
    if (load_param) begin
      weights_d = param_next[ENTRY_W-1 -: VEC_W];
      bias_d    = param_next[ACCUM_WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the blocking
  // '=' above is confined to combinational next-state logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      in_vec_q  <= '0;
      weights_q <= '0;
      bias_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      in_vec_q  <= in_vec_d;
      weights_q <= weights_d;
      bias_q    <= bias_d;
      result_q  <= result_d;
    end
  end

`ifdef LAYER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  // A response arriving on the limit cycle wins over the timeout.
  assign wait_expired = (state_q == ST_WAIT) && !neuron_output_valid &&
                        (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    if (state_q == ST_ISSUE)     wait_cnt_d = '0;
    else if (state_q == ST_WAIT) wait_cnt_d = wait_cnt_q + 1'b1;
    if (wait_expired)            timeout_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign wait_expired = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  assign in_ready            = (state_q == ST_IDLE);
  assign busy                = (state_q != ST_IDLE);
  assign neuron_start        = (state_q == ST_ISSUE);
  assign out_valid           = (state_q == ST_OUTPUT);
  assign out_data            = result_q;
  assign neuron_inputs_flat  = in_vec_q;
  assign neuron_weights_flat = weights_q;
  assign neuron_bias         = bias_q;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Scoreboard bench for mlp_layer_sequencer with a latency-10 neuron model.
// Build with LAYER_TIMEOUT_EN defined to exercise the timeout path.
module tb_mlp_layer_sequencer;

  localparam int NN  = 4;
  localparam int VW  = 80;
  localparam int AW  = 48;
  localparam int RW  = 80;
`ifdef LAYER_TIMEOUT_EN
  localparam int TO_CYC = 15;
`else
  localparam int TO_CYC = 255;
`endif

  localparam logic [RW-1:0] RES_NORMAL  = {20'h00103, 20'h00102, 20'h00101, 20'h00100};
  localparam logic [RW-1:0] RES_SILENT1 = {20'h00103, 20'h00102, 20'h00000, 20'h00100};
  localparam logic [VW-1:0] W2          = 80'h00005_00004_00003_00002;
  localparam logic [AW-1:0] B2          = 48'h10;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [VW-1:0] in_data;
  logic          wr_en;
  logic [1:0]    wr_addr;
  logic [VW-1:0] wr_weights;
  logic [AW-1:0] wr_bias;
  logic          neuron_start;
  logic [VW-1:0] neuron_inputs_flat, neuron_weights_flat;
  logic [AW-1:0] neuron_bias;
  logic [19:0]   neuron_output_data;
  logic          neuron_output_valid;
  logic          out_valid, out_ready;
  logic [RW-1:0] out_data;
  logic          busy, timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  mlp_layer_sequencer #(
    .INPUT_WIDTH(20), .ACCUM_WIDTH(48), .OUTPUT_WIDTH(20),
    .NUM_INPUTS(4), .NUM_NEURONS(NN), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_weights(wr_weights), .wr_bias(wr_bias),
    .neuron_start(neuron_start), .neuron_inputs_flat(neuron_inputs_flat),
    .neuron_weights_flat(neuron_weights_flat), .neuron_bias(neuron_bias),
    .neuron_output_data(neuron_output_data), .neuron_output_valid(neuron_output_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Neuron model: answers 10 cycles after start with 0x100 + neuron index.
  int model_cnt  = 0;
  int silent_idx = -1;
  initial begin
    neuron_output_valid = 1'b0;
    neuron_output_data  = '0;
    forever begin
      @(negedge clk);
      if (neuron_start && !rst) begin
        automatic int idx = model_cnt;
        model_cnt = (model_cnt + 1) % NN;
        repeat (9) @(posedge clk);
        #1;
        if (idx != silent_idx) begin
          neuron_output_valid = 1'b1;
          neuron_output_data  = 20'h00100 + 20'(idx);
          @(posedge clk);
          #1;
          neuron_output_valid = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor.
  logic [RW-1:0] exp_q[$];
  int   layer_starts = 0;
  logic prev_start = 1'b0, prev_nov = 1'b0, prev_ov = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      layer_starts = 0;
      prev_start = 1'b0; prev_nov = 1'b0; prev_ov = 1'b0;
    end else begin
      if (neuron_start) begin
        check("start_width", prev_start, 1'b0);
        layer_starts++;
      end
      if (out_valid && !prev_ov) check("out_valid_latency", prev_nov, 1'b1);
      if (out_valid && out_ready) begin
        check("sb_expect_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
        check("start_count", layer_starts, NN);
        layer_starts = 0;
      end
      prev_start = neuron_start;
      prev_nov   = neuron_output_valid;
      prev_ov    = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_bank(input int a, input logic [VW-1:0] w, input logic [AW-1:0] b);
    wr_en = 1'b1; wr_addr = 2'(a); wr_weights = w; wr_bias = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic send_vector(input logic [VW-1:0] v);
    int n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    check("in_ready_before_send", in_ready, 1'b1);
    in_valid = 1'b1; in_data = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_starts(input int n);
    int k = 0;
    while (layer_starts < n && k < 300) begin @(negedge clk); k++; end
    check("wait_starts", layer_starts >= n, 1'b1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 500) begin @(negedge clk); k++; end
    check("wait_idle", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 0; in_data = '0; wr_en = 0; wr_addr = '0; wr_weights = '0; wr_bias = '0;
    out_ready = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_start", neuron_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_weights", neuron_weights_flat, '0);
    check("rst_bias", neuron_bias, '0);
    @(negedge clk) rst = 1'b0;
    tick();

    // Normal layer; bank 2 holds the directed weights.
    for (int i = 0; i < NN; i++)
      if (i == 2) write_bank(i, W2, B2);
      else write_bank(i, {4{20'(i + 1)}}, 48'(i));
    exp_q.push_back(RES_NORMAL);
    send_vector(80'h11111_22222_33333_44444);
    wait_starts(3);
    repeat (2) @(negedge clk);
    check("n2_inputs", neuron_inputs_flat, 80'h11111_22222_33333_44444);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("n2_weights_stable", neuron_weights_flat, W2);
      check("n2_bias_stable", neuron_bias, B2);
    end
    wait_idle();

    // Downstream stall in OUTPUT.
    out_ready = 1'b0;
    exp_q.push_back(RES_NORMAL);
    send_vector(80'h0000A_0000B_0000C_0000D);
    begin
      int k = 0;
      logic [RW-1:0] held;
      while (!out_valid && k < 300) begin @(negedge clk); k++; end
      check("stall_reached_output", out_valid, 1'b1);
      held = out_data;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        check("stall_out_valid", out_valid, 1'b1);
        check("stall_out_data", out_data, held);
        check("stall_in_ready", in_ready, 1'b0);
        if (i == 5) begin in_valid = 1'b1; in_data = 80'hFFFFF_FFFFF_FFFFF_FFFFF; end
        if (i == 6) in_valid = 1'b0;
      end
    end
    tick();
    out_ready = 1'b1;
    wait_idle();
    repeat (2) @(negedge clk);
    check("stall_no_accept", busy, 1'b0);

    // Write attempt to bank 2 during neuron 1's WAIT is ignored.
    exp_q.push_back(RES_NORMAL);
    send_vector(80'h12345_6789A_BCDEF_01234);
    wait_starts(2);
    repeat (2) @(negedge clk);
    write_bank(2, 80'hAAAAA_BBBBB_CCCCC_DDDDD, 48'hDEAD);
    wait_starts(3);
    repeat (2) @(negedge clk);
    check("wait_write_ignored_w", neuron_weights_flat, W2);
    check("wait_write_ignored_b", neuron_bias, B2);
    wait_idle();

    // Reset during neuron 1's WAIT.
    send_vector(80'h55555_66666_77777_88888);
    wait_starts(2);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_start", neuron_start, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_out_data", out_data, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check("postrst_in_ready", in_ready, 1'b1);
    repeat (15) tick();
    model_cnt = 0;
    exp_q.push_back(RES_NORMAL);
    send_vector(80'h00001_00002_00003_00004);
    wait_starts(1);
    repeat (2) @(negedge clk);
    check("postrst_bank_w", neuron_weights_flat, '0);
    check("postrst_bank_b", neuron_bias, '0);
    wait_idle();

    // Neuron 1 never answers.
    check("pre_silent_timeout_err", timeout_err, 1'b0);
    silent_idx = 1;
`ifdef LAYER_TIMEOUT_EN
    exp_q.push_back(RES_SILENT1);
    send_vector(80'h00009_00008_00007_00006);
    wait_idle();
    check("timeout_err_set", timeout_err, 1'b1);
    silent_idx = -1;
    exp_q.push_back(RES_NORMAL);
    send_vector(80'h00006_00007_00008_00009);
    wait_idle();
    check("timeout_err_sticky", timeout_err, 1'b1);
`else
    send_vector(80'h00009_00008_00007_00006);
    repeat (300) @(negedge clk);
    check("silent_busy", busy, 1'b1);
    check("silent_out_valid", out_valid, 1'b0);
    check("silent_timeout_err", timeout_err, 1'b0);
    check("silent_slot0_kept", out_data[19:0], RES_SILENT1[19:0]);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    silent_idx = -1;
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
